// File: rtl/freq_meter.sv
// freq_meter: measures the rate of an asynchronous square wave by counting its
// rising edges over a gate of GATE_CYCLES clkin cycles. The count is published
// on freq together with a one-cycle valid strobe. Runs single-shot or continuous.
module freq_meter #(
  parameter int unsigned GATE_CYCLES = 50000000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clkin,
  input  logic             clrn,
  input  logic             sig_in,
  input  logic             start,
  input  logic             cont,
  output logic [CNT_W-1:0] freq,
  output logic             valid,
  output logic             busy,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEAS = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0]      GATE_LAST = 32'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           next_state;
  logic             s1;
  logic             s2;
  logic             s3;
  logic             edge_det;
  logic [31:0]      gate_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic             sat;

  // Synchronizer plus delay flop; keeps running in every state so a level
  // that is already high when the gate opens never looks like a fresh edge.
  always_ff @(posedge clkin or negedge clrn) begin
    if (!clrn) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edge_det = s2 & ~s3;

  // State register.
  always_ff @(posedge clkin or negedge clrn) begin
    if (!clrn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode; busy also covers the DONE cycle when re-arming so it
  // does not blink low between back-to-back gates.
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = MEAS;
        end
      end
      MEAS: begin
        busy = 1'b1;
        if (gate_cnt == GATE_LAST) begin
          next_state = DONE;
        end
      end
      DONE: begin
        if (cont || start) begin
          next_state = MEAS;
          busy       = 1'b1;
        end else begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Gate and edge counters: advance only while the gate is open and sit at
  // zero otherwise, so every new gate starts from a clean count. sat records
  // that an edge arrived while the counter was already pinned at its maximum.
  always_ff @(posedge clkin or negedge clrn) begin
    if (!clrn) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      sat      <= 1'b0;
    end else if (state == MEAS) begin
      gate_cnt <= gate_cnt + 32'd1;
      if (edge_det) begin
        if (edge_cnt == CNT_MAX) begin
          sat <= 1'b1;
        end else begin
          edge_cnt <= edge_cnt + CNT_ONE;
        end
      end
    end else begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      sat      <= 1'b0;
    end
  end

  // Result registers: loaded only in the DONE cycle, so they hold steady for
  // the whole of the following gate; valid is registered alongside them.
  always_ff @(posedge clkin or negedge clrn) begin
    if (!clrn) begin
      freq  <= '0;
      ovf   <= 1'b0;
      valid <= 1'b0;
    end else begin
      valid <= (state == DONE);
      if (state == DONE) begin
        freq <= edge_cnt;
        ovf  <= sat;
      end
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: self-checking bench for freq_meter. Two instances: a 1000-cycle
// gate with a 32-bit counter and a 100-cycle gate with a 4-bit counter. The
// expected count comes from a list of recorded sig_in rise cycles filtered by
// the gate window.
`timescale 1ns/1ps
module tb_freq_meter;

  localparam int G  = 1000;
  localparam int GS = 100;

  logic        clkin = 1'b0;
  logic        clrn;
  logic        sig_in = 1'b0;
  logic        start;
  logic        start_s;
  logic        cont;
  logic [31:0] freq;
  logic        valid;
  logic        busy;
  logic        ovf;
  logic [3:0]  freq_s;
  logic        valid_s;
  logic        busy_s;
  logic        ovf_s;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   sig_period = 4;
  int   sig_phase = 0;
  bit   sig_en = 1'b0;
  logic sig_man = 1'b0;
  int   rise_q[$];

  freq_meter #(.GATE_CYCLES(G), .CNT_W(32)) dut (
    .clkin(clkin), .clrn(clrn), .sig_in(sig_in), .start(start), .cont(cont),
    .freq(freq), .valid(valid), .busy(busy), .ovf(ovf)
  );

  freq_meter #(.GATE_CYCLES(GS), .CNT_W(4)) dut_s (
    .clkin(clkin), .clrn(clrn), .sig_in(sig_in), .start(start_s), .cont(cont),
    .freq(freq_s), .valid(valid_s), .busy(busy_s), .ovf(ovf_s)
  );

  // 50 MHz clock.
  always #10 clkin = ~clkin;

  // Cycle index: cycle k is the period that begins at the k-th rising edge.
  always @(posedge clkin) cyc <= cyc + 1;

  // sig_in source: changes 1 ns after the falling edge, well away from the
  // sampling edge, and logs the cycle of every rising transition.
  always @(negedge clkin) begin
    logic nxt;
    #1;
    if (sig_en) nxt = (((cyc - sig_phase) % sig_period) < (sig_period / 2));
    else        nxt = sig_man;
    if (nxt && !sig_in) rise_q.push_back(cyc);
    sig_in = nxt;
  end

  // Reference: a rise during cycle r is seen two cycles later (cycle r+2) and
  // counts if that cycle lies in the gate, i.e. cycles p+1 .. p+g when start
  // was accepted in cycle p.
  function automatic int exp_count(input int p, input int g);
    int n = 0;
    foreach (rise_q[i]) begin
      if ((rise_q[i] + 2 >= p + 1) && (rise_q[i] + 2 <= p + g)) n++;
    end
    return n;
  endfunction

  task automatic set_pattern(input int period);
    @(negedge clkin);
    sig_period = period;
    sig_phase  = cyc - $urandom_range(0, period - 1);
    sig_en     = 1'b1;
  endtask

  task automatic pulse_start(input bit sel, output int p);
    @(negedge clkin);
    if (sel) start_s = 1'b1;
    else     start   = 1'b1;
    p = cyc;
    @(negedge clkin);
    start   = 1'b0;
    start_s = 1'b0;
  endtask

  task automatic observe(input bit sel, input int n, output int busy_n, output int valid_n,
                         output int vcyc, output logic [31:0] vf, output logic vo);
    busy_n = 0; valid_n = 0; vcyc = -1; vf = '0; vo = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (sel ? busy_s : busy) busy_n++;
      if (sel ? valid_s : valid) begin
        valid_n++;
        vcyc = cyc;
        vf   = sel ? {28'd0, freq_s} : freq;
        vo   = sel ? ovf_s : ovf;
      end
      @(negedge clkin);
    end
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    set_pattern(6);
    repeat (10) @(negedge clkin);
    total++; if (freq !== 32'd0) begin bad++; $display("[TB] FAIL rst_freq got=%0d exp=0", freq); end
    total++; if (valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_valid got=%b exp=0", valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy got=%b exp=0", busy); end
    total++; if (ovf !== 1'b0) begin bad++; $display("[TB] FAIL rst_ovf got=%b exp=0", ovf); end
    total++; if ({freq_s, valid_s, busy_s, ovf_s} !== 7'd0) begin
      bad++; $display("[TB] FAIL rst_small got=%b exp=0", {freq_s, valid_s, busy_s, ovf_s});
    end
    clrn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clkin);
      total++;
      if ({freq, valid, busy, ovf} !== 35'd0) begin
        bad++; $display("[TB] FAIL idle_after_release cyc=%0d got freq=%0d valid=%b busy=%b ovf=%b exp all 0",
                        cyc, freq, valid, busy, ovf);
      end
    end
  endtask

  task automatic test_single();
    int p, bn, vn, vc, ex;
    logic [31:0] vf;
    logic vo;
    set_pattern(5);
    repeat (3) @(negedge clkin);
    pulse_start(1'b0, p);
    observe(1'b0, G + 40, bn, vn, vc, vf, vo);
    ex = exp_count(p, G);
    total++; if (bn != G) begin bad++; $display("[TB] FAIL single_busy_len got=%0d exp=%0d", bn, G); end
    total++; if (vn != 1) begin bad++; $display("[TB] FAIL single_valid_cnt got=%0d exp=1", vn); end
    total++; if (vc != p + G + 2) begin bad++; $display("[TB] FAIL single_valid_cyc got=%0d exp=%0d", vc, p + G + 2); end
    total++; if (vf !== 32'(ex)) begin bad++; $display("[TB] FAIL single_freq got=%0d exp=%0d", vf, ex); end
    total++; if (vf !== 32'd200) begin bad++; $display("[TB] FAIL single_freq200 got=%0d exp=200", vf); end
    total++; if (vo !== 1'b0) begin bad++; $display("[TB] FAIL single_ovf got=%b exp=0", vo); end
    total++; if (busy !== 1'b0 || freq !== vf) begin
      bad++; $display("[TB] FAIL single_idle_hold got busy=%b freq=%0d exp busy=0 freq=%0d", busy, freq, vf);
    end
  endtask

  task automatic test_random();
    int p, bn, vn, vc, ex, per;
    logic [31:0] vf;
    logic vo;
    for (int r = 0; r < 3; r++) begin
      per = $urandom_range(4, 40);
      set_pattern(per);
      repeat (2) @(negedge clkin);
      pulse_start(1'b0, p);
      observe(1'b0, G + 20, bn, vn, vc, vf, vo);
      ex = exp_count(p, G);
      total++;
      if (vn != 1 || vf !== 32'(ex) || vo !== 1'b0 || vc != p + G + 2) begin
        bad++; $display("[TB] FAIL random_run%0d period=%0d got freq=%0d ovf=%b valids=%0d at %0d exp freq=%0d ovf=0 valids=1 at %0d",
                        r, per, vf, vo, vn, vc, ex, p + G + 2);
      end
    end
  endtask

  task automatic test_continuous();
    int p, bn, k, ex;
    int vc[3];
    logic [31:0] vfq[3];
    set_pattern(20);
    cont = 1'b1;
    repeat (2) @(negedge clkin);
    pulse_start(1'b0, p);
    bn = 0; k = 0;
    for (int i = 0; i < 3 * (G + 1) + 40; i++) begin
      if (busy) bn++;
      if (valid) begin
        if (k < 3) begin vc[k] = cyc; vfq[k] = freq; end
        k++;
        if (k == 2) cont = 1'b0;
      end
      @(negedge clkin);
    end
    cont = 1'b0;
    total++; if (k != 3) begin bad++; $display("[TB] FAIL cont_valid_cnt got=%0d exp=3", k); end
    total++; if (bn != 3 * G + 2) begin bad++; $display("[TB] FAIL cont_busy_len got=%0d exp=%0d", bn, 3 * G + 2); end
    if (k >= 3) begin
      for (int j = 0; j < 3; j++) begin
        ex = exp_count(p + j * (G + 1), G);
        total++;
        if (vc[j] != p + G + 2 + j * (G + 1) || vfq[j] !== 32'(ex)) begin
          bad++; $display("[TB] FAIL cont_result%0d got cyc=%0d freq=%0d exp cyc=%0d freq=%0d",
                          j, vc[j], vfq[j], p + G + 2 + j * (G + 1), ex);
        end
      end
      total++; if (vfq[1] !== 32'd50) begin bad++; $display("[TB] FAIL cont_freq50 got=%0d exp=50", vfq[1]); end
    end
  endtask

  task automatic test_back_to_back();
    int p, bn, k, c;
    int vc[2];
    logic [31:0] vfq[2];
    set_pattern($urandom_range(4, 30));
    repeat (2) @(negedge clkin);
    pulse_start(1'b0, p);
    bn = 0; k = 0;
    for (int i = 0; i < 2 * G + 40; i++) begin
      c = cyc;
      start = (c == p + G + 1);
      #1;
      if (busy) bn++;
      if (valid) begin
        if (k < 2) begin vc[k] = c; vfq[k] = freq; end
        k++;
      end
      @(negedge clkin);
    end
    start = 1'b0;
    total++; if (k != 2) begin bad++; $display("[TB] FAIL b2b_valid_cnt got=%0d exp=2", k); end
    total++; if (bn != 2 * G + 1) begin bad++; $display("[TB] FAIL b2b_busy_len got=%0d exp=%0d", bn, 2 * G + 1); end
    if (k >= 2) begin
      total++;
      if (vc[1] - vc[0] != G + 1 || vfq[0] !== 32'(exp_count(p, G)) || vfq[1] !== 32'(exp_count(p + G + 1, G))) begin
        bad++; $display("[TB] FAIL b2b_results got gap=%0d f0=%0d f1=%0d exp gap=%0d f0=%0d f1=%0d",
                        vc[1] - vc[0], vfq[0], vfq[1], G + 1, exp_count(p, G), exp_count(p + G + 1, G));
      end
    end
  endtask

  task automatic test_saturation();
    int p, bn, vn, vc, ex, per;
    logic [31:0] vf, ef;
    logic vo, eo;
    for (int r = 0; r < 2; r++) begin
      per = (r == 0) ? 4 : 10;
      set_pattern(per);
      repeat (2) @(negedge clkin);
      pulse_start(1'b1, p);
      observe(1'b1, GS + 20, bn, vn, vc, vf, vo);
      ex = exp_count(p, GS);
      ef = (ex > 15) ? 32'd15 : 32'(ex);
      eo = (ex > 15);
      total++;
      if (vn != 1 || bn != GS || vf !== ef || vo !== eo) begin
        bad++; $display("[TB] FAIL sat_run%0d period=%0d got freq=%0d ovf=%b valids=%0d busy=%0d exp freq=%0d ovf=%b valids=1 busy=%0d",
                        r, per, vf, vo, vn, bn, ef, eo, GS);
      end
    end
    total++; if (freq_s !== 4'd10 || ovf_s !== 1'b0) begin
      bad++; $display("[TB] FAIL sat_recover got freq=%0d ovf=%b exp freq=10 ovf=0", freq_s, ovf_s);
    end
  endtask

  task automatic test_boundary();
    int p, c, bn, vn, vc, ex;
    int ra[2];
    int rb[2];
    logic [31:0] vf;
    ra[0] = -1; rb[0] = G - 2;
    ra[1] = -2; rb[1] = G - 1;
    sig_en  = 1'b0;
    sig_man = 1'b0;
    for (int r = 0; r < 2; r++) begin
      repeat (5) @(negedge clkin);
      p = cyc + 2;
      bn = 0; vn = 0; vc = -1; vf = '0;
      for (int i = 0; i < G + 40; i++) begin
        c = cyc;
        sig_man = ((c >= p + ra[r]) && (c < p + ra[r] + 2)) || ((c >= p + rb[r]) && (c < p + rb[r] + 2));
        if (c == p)                    start = 1'b1;
        else if (c > p && c <= p + G)  start = ($urandom_range(0, 3) == 0);
        else                           start = 1'b0;
        #1;
        if (busy) bn++;
        if (valid) begin vn++; vc = c; vf = freq; end
        @(negedge clkin);
      end
      start = 1'b0;
      ex = exp_count(p, G);
      total++; if (bn != G) begin bad++; $display("[TB] FAIL bound%0d_busy_len got=%0d exp=%0d", r, bn, G); end
      total++;
      if (vn != 1 || vc != p + G + 2 || vf !== 32'(ex)) begin
        bad++; $display("[TB] FAIL bound%0d_result got freq=%0d valids=%0d at %0d exp freq=%0d valids=1 at %0d",
                        r, vf, vn, vc, ex, p + G + 2);
      end
      total++;
      if (vf !== ((r == 0) ? 32'd2 : 32'd0)) begin
        bad++; $display("[TB] FAIL bound%0d_edges got=%0d exp=%0d", r, vf, (r == 0) ? 2 : 0);
      end
    end
  endtask

  task automatic test_reset_mid();
    int p, bn, vn, vc;
    logic [31:0] vf;
    logic vo;
    set_pattern(5);
    repeat (2) @(negedge clkin);
    pulse_start(1'b0, p);
    repeat (499) @(negedge clkin);
    clrn = 1'b0;
    #1;
    total++;
    if ({freq, valid, busy, ovf} !== 35'd0) begin
      bad++; $display("[TB] FAIL midrst_outputs got freq=%0d valid=%b busy=%b ovf=%b exp all 0", freq, valid, busy, ovf);
    end
    repeat (5) @(negedge clkin);
    clrn = 1'b1;
    observe(1'b0, G, bn, vn, vc, vf, vo);
    total++;
    if (vn != 0 || bn != 0) begin
      bad++; $display("[TB] FAIL midrst_no_valid got valids=%0d busy=%0d exp 0 0", vn, bn);
    end
    pulse_start(1'b0, p);
    observe(1'b0, G + 20, bn, vn, vc, vf, vo);
    total++;
    if (vn != 1 || vf !== 32'(exp_count(p, G)) || vf !== 32'd200 || vo !== 1'b0) begin
      bad++; $display("[TB] FAIL midrst_rerun got freq=%0d ovf=%b valids=%0d exp freq=%0d ovf=0 valids=1",
                      vf, vo, vn, exp_count(p, G));
    end
  endtask

  initial begin
    clrn    = 1'b0;
    start   = 1'b0;
    start_s = 1'b0;
    cont    = 1'b0;
    $display("[TB] freq_meter bench starting");
    test_reset();
    test_single();
    test_random();
    test_continuous();
    test_back_to_back();
    test_saturation();
    test_boundary();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
